// File: rtl/ka_pkg.sv
// Shared constants and FSM state type for the 49-bit sequential Karatsuba multiplier.
package ka_pkg;
  localparam int KA_N  = 49;
  localparam int KA_H  = 25;
  localparam int KA_YW = 97;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    MX,
    DONE
  } ka49_state_t;
endpackage

// File: rtl/KA_25bit.sv
// Combinational 25x25 carry-less (GF(2)[x]) multiplier core, 49-bit product.
module KA_25bit (
  input  logic [24:0] a,
  input  logic [24:0] b,
  output logic [48:0] y
);

  // Accumulate shifted copies of a for every set coefficient of b, XOR only.
  always_comb begin
    y = '0;
    for (int i = 0; i < 25; i++) begin
      if (b[i]) y = y ^ (49'(a) << i);
    end
  end

endmodule

// File: rtl/ka49_seq_mult_recombine.sv
// Karatsuba recombination: y = P0 ^ (mid << H) ^ (P1 << 2H), carry-less.
module ka49_recombine
  import ka_pkg::*;
(
  input  logic [2*KA_H-2:0] p0,
  input  logic [2*KA_H-2:0] p1,
  input  logic [2*KA_H-2:0] mid,
  output logic [KA_YW-1:0]  y
);

  // P1 carries at most 47 significant bits, so the truncation to 97 bits loses nothing.
  always_comb begin
    y = KA_YW'(p0) ^ (KA_YW'(mid) << KA_H) ^ (KA_YW'(p1) << (2 * KA_H));
  end

endmodule

// File: rtl/ka49_seq_mult.sv
// 49-bit carry-less multiplier time-multiplexing one 25-bit Karatsuba core over
// three cycles (low, high, cross term), with valid/ready on both sides.
module ka49_seq_mult
  import ka_pkg::*;
#(
  parameter int N = KA_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);

  localparam int H = (N + 1) / 2;

  ka49_state_t    state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*H-2:0] p0_q, p0_d, p1_q, p1_d;
  logic [2*N-2:0] y_q, y_d;

  logic [H-1:0]   a0, a1, b0, b1;
  logic [H-1:0]   core_a, core_b;
  logic [2*H-2:0] core_p, mid;
  logic [2*N-2:0] y_mx;
  logic           in_acc;

  assign a0 = a_q[H-1:0];
  assign a1 = {1'b0, a_q[N-1:H]};
  assign b0 = b_q[H-1:0];
  assign b1 = {1'b0, b_q[N-1:H]};

  assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign in_acc    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == M0) || (state_q == M1) || (state_q == MX);
  assign y         = y_q;

  // Select the core operands for the current partial product.
  always_comb begin
    core_a = a0;
    core_b = b0;
    unique case (state_q)
      M1: begin
        core_a = a1;
        core_b = b1;
      end
      MX: begin
        core_a = a0 ^ a1;
        core_b = b0 ^ b1;
      end
      default: begin
        core_a = a0;
        core_b = b0;
      end
    endcase
  end

  KA_25bit u_core (
    .a (core_a),
    .b (core_b),
    .y (core_p)
  );

  // Cross term is available only during MX, where core_p is (a0^a1)(b0^b1).
  assign mid = p0_q ^ p1_q ^ core_p;

  ka49_recombine u_recombine (
    .p0  (p0_q),
    .p1  (p1_q),
    .mid (mid),
    .y   (y_mx)
  );

  // Next-state and datapath register updates; flush overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    y_d     = y_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_acc) state_d = M0;
        end
        M0: begin
          p0_d    = core_p;
          state_d = M1;
        end
        M1: begin
          p1_d    = core_p;
          state_d = MX;
        end
        MX: begin
          y_d     = y_mx;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = in_valid ? M0 : IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (in_acc) begin
        a_d = a;
        b_d = b;
      end
    end
  end

  // State and data registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      y_q     <= y_d;
    end
  end

endmodule
